// File: rtl/herald_host_bridge.sv
`default_nettype none
// ============================================================================
// Module   : herald_host_bridge
// Brief    : Host-side master for the Herald coprocessor pin bus. Serialises a
//            command and its operands with WR strobes, waits out BUSY, then
//            collects the result bytes with RD strobes.
// Revision : 1.0 - initial release
// ============================================================================
module herald_host_bridge #(
    parameter int STROBE_HIGH    = 2,
    parameter int STROBE_LOW     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  cmd,
    input  logic [23:0] op_a,
    input  logic [23:0] op_b,
    output logic [7:0]  bus_out,
    output logic        wr_strobe,
    output logic        rd_strobe,
    input  logic [7:0]  bus_in,
    output logic [71:0] result,
    output logic [3:0]  result_len,
    output logic        done,
    output logic        err,
    output logic        busy
);

    localparam int c_PH_MAX = (STROBE_HIGH > STROBE_LOW) ? STROBE_HIGH : STROBE_LOW;
    localparam int c_PW     = (c_PH_MAX > 1) ? $clog2(c_PH_MAX) : 1;
    localparam int c_TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [c_PW-1:0] c_SH_LAST = c_PW'(STROBE_HIGH - 1);
    localparam logic [c_PW-1:0] c_SL_LAST = c_PW'(STROBE_LOW - 1);
    localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_SETUP   = 3'd1;
    localparam logic [2:0] c_ST_WR_HI   = 3'd2;
    localparam logic [2:0] c_ST_WR_LO   = 3'd3;
    localparam logic [2:0] c_ST_WAIT_HI = 3'd4;
    localparam logic [2:0] c_ST_WAIT_LO = 3'd5;
    localparam logic [2:0] c_ST_RD_HI   = 3'd6;
    localparam logic [2:0] c_ST_RD_LO   = 3'd7;

    logic [2:0]      r_state;
    logic [c_PW-1:0] r_phase;
    logic [c_TW-1:0] r_wait;
    logic [7:0]      r_cmd;
    logic [23:0]     r_op_a;
    logic [23:0]     r_op_b;
    logic [2:0]      r_nwr;
    logic [3:0]      r_nrd;
    logic [2:0]      r_wr_idx;
    logic [3:0]      r_rd_idx;
    logic [1:0]      r_cap;
    logic [7:0]      r_bus_out;
    logic            r_wr;
    logic            r_rd;
    logic [71:0]     r_result;
    logic [3:0]      r_result_len;
    logic            r_done;
    logic            r_err;
    logic            r_busy;

    logic            w_cmd_ok;
    logic [2:0]      w_nwr;
    logic [3:0]      w_nrd;
    logic [2:0]      w_next_idx;
    logic [7:0]      w_next_byte;
    logic            w_wait_expired;

    // Command table: number of bytes written (cmd + operands) and read back.
    always_comb begin
        w_cmd_ok = 1'b1;
        w_nwr    = 3'd7;
        w_nrd    = 4'd3;
        case (cmd)
            8'h10: begin
                w_nwr = 3'd4;
                w_nrd = 4'd6;
            end
            8'h11, 8'h12, 8'h20, 8'h21: begin
                w_nwr = 3'd7;
                w_nrd = 4'd3;
            end
            8'h13: begin
                w_nwr = 3'd7;
                w_nrd = 4'd9;
            end
            8'h23: begin
                w_nwr = 3'd4;
                w_nrd = 4'd3;
            end
            8'h22: begin
                w_nwr = 3'd1;
                w_nrd = 4'd0;
            end
            default: begin
                w_cmd_ok = 1'b0;
                w_nwr    = 3'd0;
                w_nrd    = 4'd0;
            end
        endcase
    end

    always_comb begin
        w_next_idx = r_wr_idx + 3'd1;
        case (w_next_idx)
            3'd0:    w_next_byte = r_cmd;
            3'd1:    w_next_byte = r_op_a[7:0];
            3'd2:    w_next_byte = r_op_a[15:8];
            3'd3:    w_next_byte = r_op_a[23:16];
            3'd4:    w_next_byte = r_op_b[7:0];
            3'd5:    w_next_byte = r_op_b[15:8];
            3'd6:    w_next_byte = r_op_b[23:16];
            default: w_next_byte = 8'h00;
        endcase
    end

    assign w_wait_expired = (r_wait == c_TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_phase      <= '0;
            r_wait       <= '0;
            r_cmd        <= 8'h00;
            r_op_a       <= 24'h0;
            r_op_b       <= 24'h0;
            r_nwr        <= 3'd0;
            r_nrd        <= 4'd0;
            r_wr_idx     <= 3'd0;
            r_rd_idx     <= 4'd0;
            r_cap        <= 2'b00;
            r_bus_out    <= 8'h00;
            r_wr         <= 1'b0;
            r_rd         <= 1'b0;
            r_result     <= 72'h0;
            r_result_len <= 4'd0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_cap  <= {r_cap[0], 1'b0};

            // The coprocessor drives the byte one clock after it sees RD rise,
            // so the capture lands two clocks after the rising edge.
            if (r_cap[1]) begin
                for (int k = 0; k < 9; k++) begin
                    if (r_result_len == 4'(k)) begin
                        r_result[k*8 +: 8] <= bus_in;
                    end
                end
                r_result_len <= r_result_len + 4'd1;
            end

            case (r_state)
                c_ST_IDLE: begin
                    r_bus_out <= 8'h00;
                    if (r_busy) begin
                        r_busy <= 1'b0;
                    end else if (start) begin
                        r_busy       <= 1'b1;
                        r_result     <= 72'h0;
                        r_result_len <= 4'd0;
                        r_cmd        <= cmd;
                        r_op_a       <= op_a;
                        r_op_b       <= op_b;
                        r_nwr        <= w_nwr;
                        r_nrd        <= w_nrd;
                        r_wr_idx     <= 3'd0;
                        if (w_cmd_ok) begin
                            r_bus_out <= cmd;
                            r_state   <= c_ST_SETUP;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end

                c_ST_SETUP: begin
                    r_wr    <= 1'b1;
                    r_phase <= '0;
                    r_state <= c_ST_WR_HI;
                end

                c_ST_WR_HI: begin
                    if (r_phase == c_SH_LAST) begin
                        r_wr    <= 1'b0;
                        r_phase <= '0;
                        r_state <= c_ST_WR_LO;
                    end else begin
                        r_phase <= r_phase + c_PW'(1);
                    end
                end

                c_ST_WR_LO: begin
                    if (r_phase == c_SL_LAST) begin
                        r_phase <= '0;
                        if (w_next_idx == r_nwr) begin
                            r_bus_out <= 8'h00;
                            r_wait    <= '0;
                            r_state   <= c_ST_WAIT_HI;
                        end else begin
                            r_wr_idx  <= w_next_idx;
                            r_bus_out <= w_next_byte;
                            r_state   <= c_ST_SETUP;
                        end
                    end else begin
                        r_phase <= r_phase + c_PW'(1);
                    end
                end

                c_ST_WAIT_HI: begin
                    if (bus_in[7]) begin
                        r_wait  <= '0;
                        r_state <= c_ST_WAIT_LO;
                    end else if (w_wait_expired) begin
                        r_err   <= 1'b1;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_wait <= r_wait + c_TW'(1);
                    end
                end

                c_ST_WAIT_LO: begin
                    if (!bus_in[7]) begin
                        if (r_nrd == 4'd0) begin
                            r_done  <= 1'b1;
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_rd     <= 1'b1;
                            r_phase  <= '0;
                            r_rd_idx <= 4'd0;
                            r_cap    <= {r_cap[0], 1'b1};
                            r_state  <= c_ST_RD_HI;
                        end
                    end else if (w_wait_expired) begin
                        r_err   <= 1'b1;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_wait <= r_wait + c_TW'(1);
                    end
                end

                c_ST_RD_HI: begin
                    if (r_phase == c_SH_LAST) begin
                        r_rd    <= 1'b0;
                        r_phase <= '0;
                        r_state <= c_ST_RD_LO;
                    end else begin
                        r_phase <= r_phase + c_PW'(1);
                    end
                end

                c_ST_RD_LO: begin
                    if (r_phase == c_SL_LAST) begin
                        r_phase <= '0;
                        if (r_rd_idx == r_nrd - 4'd1) begin
                            r_done  <= 1'b1;
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_rd_idx <= r_rd_idx + 4'd1;
                            r_rd     <= 1'b1;
                            r_cap    <= {r_cap[0], 1'b1};
                            r_state  <= c_ST_RD_HI;
                        end
                    end else begin
                        r_phase <= r_phase + c_PW'(1);
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Strobe widths below these limits would let the capture slip past RD_LO.
    always @(posedge clk) begin
        assert (STROBE_HIGH >= 1 && STROBE_LOW >= 1 && (STROBE_HIGH + STROBE_LOW) >= 2);
    end

    assign bus_out    = r_bus_out;
    assign wr_strobe  = r_wr;
    assign rd_strobe  = r_rd;
    assign result     = r_result;
    assign result_len = r_result_len;
    assign done       = r_done;
    assign err        = r_err;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_herald_host_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_herald_host_bridge
// Brief    : Table-driven bench with a coprocessor bus model and a scoreboard
//            of expected transaction outcomes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_herald_host_bridge;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        start  = 1'b0;
    logic        start2 = 1'b0;
    logic [7:0]  cmd    = 8'h00;
    logic [23:0] op_a   = 24'h0;
    logic [23:0] op_b   = 24'h0;
    logic [7:0]  bus_in = 8'h00;

    logic [7:0]  bus_out,  bus_out2;
    logic        wr_strobe, wr2, rd_strobe, rd2;
    logic [71:0] result,   result2;
    logic [3:0]  result_len, result_len2;
    logic        done, done2, err, err2, busy, busy2;

    always #5 clk = ~clk;

    herald_host_bridge u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cmd        (cmd),
        .op_a       (op_a),
        .op_b       (op_b),
        .bus_out    (bus_out),
        .wr_strobe  (wr_strobe),
        .rd_strobe  (rd_strobe),
        .bus_in     (bus_in),
        .result     (result),
        .result_len (result_len),
        .done       (done),
        .err        (err),
        .busy       (busy)
    );

    // Second bridge with a short timeout whose coprocessor never goes BUSY.
    herald_host_bridge #(.TIMEOUT_CYCLES(16)) u_dut_to (
        .clk        (clk),
        .rst        (rst),
        .start      (start2),
        .cmd        (cmd),
        .op_a       (op_a),
        .op_b       (op_b),
        .bus_out    (bus_out2),
        .wr_strobe  (wr2),
        .rd_strobe  (rd2),
        .bus_in     (8'h00),
        .result     (result2),
        .result_len (result_len2),
        .done       (done2),
        .err        (err2),
        .busy       (busy2)
    );

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] a;
        logic [23:0] b;
        int          busy_len;
        logic [71:0] rd;
        bit          mid_start;
        int          nwr;
        int          nrd;
        bit          exp_err;
    } vec_t;

    typedef struct {
        bit          is_err;
        logic [71:0] result;
        logic [3:0]  len;
        int          nwr;
        logic [55:0] wrlog;
        int          nrd;
    } exp_t;

    // Coprocessor model controls, written only by the stimulus process.
    int          m_nwr      = 0;
    int          m_busy_len = 0;
    logic [71:0] m_rd       = '0;

    // Coprocessor model state, written only by the model process.
    int          wr_cnt      = 0;
    int          rd_cnt      = 0;
    int          overlap_cnt = 0;
    int          bsy_left    = 0;
    logic [55:0] wr_log      = '0;
    logic        wr_q        = 1'b0;
    logic        rd_q        = 1'b0;

    always @(posedge clk) begin
        logic [7:0] nb;
        nb = 8'h00;
        if (rst) begin
            bsy_left = 0;
        end else begin
            if (wr_strobe && rd_strobe) overlap_cnt++;
            if (start && !busy) begin
                wr_cnt   = 0;
                rd_cnt   = 0;
                wr_log   = '0;
                bsy_left = 0;
            end
            if (wr_strobe && !wr_q) begin
                if (wr_cnt < 7) wr_log[wr_cnt*8 +: 8] = bus_out;
                wr_cnt++;
            end
            if (!wr_strobe && wr_q && wr_cnt == m_nwr) bsy_left = m_busy_len;
            if (rd_strobe && !rd_q) begin
                if (rd_cnt < 9) nb = m_rd[rd_cnt*8 +: 8];
                rd_cnt++;
            end else if (bsy_left > 0) begin
                nb = 8'h80;
                bsy_left--;
            end
        end
        wr_q = wr_strobe;
        rd_q = rd_strobe;
        bus_in <= nb;
    end

    int   w2_cnt = 0;
    int   r2_cnt = 0;
    logic w2_q   = 1'b0;
    logic r2_q   = 1'b0;

    always @(posedge clk) begin
        if (start2 && !busy2) begin
            w2_cnt = 0;
            r2_cnt = 0;
        end
        if (wr2 && !w2_q) w2_cnt++;
        if (rd2 && !r2_q) r2_cnt++;
        w2_q = wr2;
        r2_q = rd2;
    end

    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t sb_q[$];
    vec_t vecs[11];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input string name);
        exp_t        e;
        exp_t        got;
        logic [55:0] wb;
        int          cyc;
        e.is_err = v.exp_err;
        e.nwr    = v.nwr;
        e.nrd    = v.nrd;
        e.len    = 4'(v.nrd);
        e.result = '0;
        e.wrlog  = '0;
        for (int k = 0; k < v.nrd; k++) e.result[k*8 +: 8] = v.rd[k*8 +: 8];
        wb = {v.b, v.a, v.cmd};
        for (int k = 0; k < v.nwr; k++) e.wrlog[k*8 +: 8] = wb[k*8 +: 8];

        m_nwr      = v.nwr;
        m_busy_len = v.busy_len;
        m_rd       = v.rd;
        @(negedge clk);
        cmd   = v.cmd;
        op_a  = v.a;
        op_b  = v.b;
        start = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk({name, "_busy_on_start"}, busy, 1);

        cyc = 0;
        while (!done && !err && cyc < 3000) begin
            if (v.mid_start && cyc == 10) begin
                cmd   = 8'h55;
                op_a  = 24'hFFFFFF;
                op_b  = 24'hFFFFFF;
                start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end

        got = sb_q.pop_front();
        if (cyc >= 3000) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_timeout: got no done/err after %0d cycles want completion", name, cyc);
        end else begin
            chk({name, "_outcome"}, {err, done}, got.is_err ? 2'b10 : 2'b01);
            if (got.is_err) begin
                chk({name, "_err_latency"}, cyc, 0);
            end else begin
                chk({name, "_result"}, result, got.result);
                chk({name, "_result_len"}, result_len, got.len);
            end
            chk({name, "_wr_count"}, wr_cnt, got.nwr);
            chk({name, "_wr_bytes"}, wr_log, got.wrlog);
            chk({name, "_rd_count"}, rd_cnt, got.nrd);
            @(negedge clk);
            chk({name, "_pulse_end"}, {done, err, busy}, 3'b000);
            chk({name, "_bus_idle"}, bus_out, 8'h00);
        end
    endtask

    initial begin
        int cyc;
        int err_at;
        bit done2_seen;

        vecs[0]  = '{8'h12, 24'h003000, 24'h004000,  20, 72'h005000,             1'b0, 7, 3, 1'b0};
        vecs[1]  = '{8'h10, 24'h123456, 24'h777777, 100, 72'h060504030201,       1'b0, 4, 6, 1'b0};
        vecs[2]  = '{8'h13, 24'h0A0B0C, 24'h0D0E0F,  10, 72'hFF807FFF01FFC3FFA5, 1'b0, 7, 9, 1'b0};
        vecs[3]  = '{8'h22, 24'h111111, 24'h222222,   3, 72'h0,                  1'b0, 1, 0, 1'b0};
        vecs[4]  = '{8'h55, 24'h333333, 24'h444444,   0, 72'h0,                  1'b0, 0, 0, 1'b1};
        vecs[5]  = '{8'h23, 24'hABCDEF, 24'h123456,   8, 72'h3CB2E7,             1'b0, 4, 3, 1'b0};
        vecs[6]  = '{8'h20, 24'h001800, 24'h002000,  12, 72'h112233,             1'b1, 7, 3, 1'b0};
        vecs[7]  = '{8'h11, 24'hFFF000, 24'h000FFF,   5, 72'h998877,             1'b0, 7, 3, 1'b0};
        vecs[8]  = '{8'h21, 24'h800000, 24'h7FFFFF,   6, 72'hAABBCC,             1'b0, 7, 3, 1'b0};
        vecs[9]  = '{8'h00, 24'h010203, 24'h040506,   0, 72'h0,                  1'b0, 0, 0, 1'b1};
        vecs[10] = '{8'hFF, 24'h010203, 24'h040506,   0, 72'h0,                  1'b0, 0, 0, 1'b1};

        repeat (2) @(negedge clk);
        chk("reset_bus_strobes", {bus_out, wr_strobe, rd_strobe}, 10'h000);
        chk("reset_result", {result_len, result}, 76'h0);
        chk("reset_flags", {done, err, busy}, 3'b000);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i], $sformatf("v%0d", i));
        end

        // Coprocessor never raises BUSY: the short-timeout bridge gives up.
        @(negedge clk);
        cmd    = 8'h12;
        op_a   = 24'h003000;
        op_b   = 24'h004000;
        start2 = 1'b1;
        @(negedge clk);
        start2     = 1'b0;
        cyc        = 0;
        err_at     = -1;
        done2_seen = 1'b0;
        while (busy2 && cyc < 200) begin
            cyc++;
            if (err2) err_at = cyc;
            if (done2) done2_seen = 1'b1;
            @(negedge clk);
        end
        chk("timeout_busy_cycles", cyc, 52);
        chk("timeout_err_cycle", err_at, 52);
        chk("timeout_no_done", done2_seen, 0);
        chk("timeout_wr_count", w2_cnt, 7);
        chk("timeout_rd_count", r2_cnt, 0);

        // Asynchronous reset in the middle of a write sequence.
        m_nwr      = 7;
        m_busy_len = 5;
        m_rd       = 72'h010203;
        @(negedge clk);
        cmd   = 8'h11;
        op_a  = 24'h445566;
        op_b  = 24'h778899;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (!wr_strobe && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("rstmid_wr_active", {wr_strobe, busy}, 2'b11);
        #1 rst = 1'b1;
        #1;
        chk("rstmid_bus_strobes", {bus_out, wr_strobe, rd_strobe}, 10'h000);
        chk("rstmid_flags", {done, err, busy, result_len}, 7'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstmid_stays_idle", {busy, wr_strobe, bus_out}, 10'h000);
        run_txn(vecs[5], "post_reset");

        chk("strobe_overlap", overlap_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
